// File: rtl/seq_detect_pkg.sv
// Shared constants for the programmable sequence detector: FSM state
// encoding and the default sizing parameters.
package seq_detect_pkg;

  localparam int MAXLEN_DEF = 8;
  localparam int CNTW_DEF   = 8;
  localparam int LENW_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // A pattern length is usable only when it selects at least one bit and
  // fits inside the history window.
  function automatic logic lenLegal(input int len, input int maxLen);
    return (len >= 1) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial-bit matcher: keeps a shift history and a fill count, and flags a
// Mealy match when the newest len bits equal the programmed pattern.
module seq_match_core #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              x_i,
  input  logic [LENW-1:0]   len_i,
  input  logic [MAXLEN-1:0] pattern_i,
  input  logic              overlap_i,
  output logic              y_o
);

  localparam int FILLW = $clog2(MAXLEN + 1);
  localparam logic [FILLW-1:0] FILL_ONE = FILLW'(1);
  localparam logic [FILLW-1:0] FILL_MAX = FILLW'(MAXLEN);

  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [FILLW-1:0]  fill_q, fill_d;
  logic [MAXLEN-1:0] cand;
  logic              bitsMatch;
  logic              enoughBits;

  assign cand = {hist_q[MAXLEN-2:0], x_i};

  // Only the low len bits of the candidate take part in the compare.
  always_comb begin
    bitsMatch = 1'b1;
    for (int i = 0; i < MAXLEN; i++) begin
      if ((i < int'(len_i)) && (cand[i] != pattern_i[i])) begin
        bitsMatch = 1'b0;
      end
    end
  end

  assign enoughBits = (int'(fill_q) + 1) >= int'(len_i);
  assign y_o        = enable_i && enoughBits && bitsMatch;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (enable_i) begin
      hist_d = cand;
      if (y_o && !overlap_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable Mealy sequence-detector controller: config port, IDLE/RUN/HALT
// FSM, saturating match counter and sticky threshold interrupt.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF,
  parameter int LENW   = LENW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_threshold,
  input  logic              stop,
  input  logic              x_valid,
  input  logic              x,
  output logic              y,
  output logic [CNTW-1:0]   match_count,
  output logic              irq,
  input  logic              irq_clr,
  output logic              cfg_err,
  output logic [1:0]        state_o
);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pattern_q;
  logic [LENW-1:0]   len_q;
  logic              overlap_q;
  logic [CNTW-1:0]   threshold_q;
  logic [CNTW-1:0]   count_q, count_d;
  logic              irq_q, irq_d;
  logic              cfgErr_q, cfgErr_d;

  logic cfgAccept;
  logic cfgLegal;
  logic goodCfg;
  logic haltClear;
  logic coreEnable;
  logic coreClear;
  logic matchY;
  logic hitThreshold;

  assign cfgAccept  = cfg_valid && cfg_ready;
  assign cfgLegal   = lenLegal(int'(cfg_len), MAXLEN);
  assign goodCfg    = cfgAccept && cfgLegal;
  // A config arriving in HALT outranks an irq acknowledge in the same cycle.
  assign haltClear  = (state_q == ST_HALT) && irq_clr && !cfgAccept;
  assign coreEnable = (state_q == ST_RUN) && x_valid && !stop;
  assign coreClear  = goodCfg || haltClear;

  assign hitThreshold = (threshold_q != '0) &&
                        (({1'b0, count_q} + {{CNTW{1'b0}}, 1'b1}) == {1'b0, threshold_q});

  seq_match_core #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (coreClear),
    .enable_i  (coreEnable),
    .x_i       (x),
    .len_i     (len_q),
    .pattern_i (pattern_q),
    .overlap_i (overlap_q),
    .y_o       (matchY)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfgAccept) state_d = cfgLegal ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (stop)                        state_d = ST_IDLE;
        else if (matchY && hitThreshold) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (cfgAccept)    state_d = cfgLegal ? ST_RUN : ST_IDLE;
        else if (irq_clr) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q != ST_RUN);
    state_o   = state_q;
    y         = matchY;
  end

  always_comb begin
    count_d  = count_q;
    irq_d    = irq_q;
    cfgErr_d = cfgErr_q;
    if (cfgAccept) cfgErr_d = !cfgLegal;
    if (coreClear) begin
      count_d = '0;
      irq_d   = 1'b0;
    end else if (matchY) begin
      if (count_q != '1) count_d = count_q + CNTW'(1);
      if (hitThreshold)  irq_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      threshold_q <= '0;
      count_q     <= '0;
      irq_q       <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      if (goodCfg) begin
        pattern_q   <= cfg_pattern;
        len_q       <= cfg_len;
        overlap_q   <= cfg_overlap;
        threshold_q <= cfg_threshold;
      end
      count_q  <= count_d;
      irq_q    <= irq_d;
      cfgErr_q <= cfgErr_d;
    end
  end

  assign match_count = count_q;
  assign irq         = irq_q;
  assign cfg_err     = cfgErr_q;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable Mealy sequence-detector controller for the serial-bit FSM family. Software loads a pattern (1..MAXLEN bits), a match threshold and the overlap/non-overlap mode through a valid/ready config port. The block then scans a qualified serial stream and emits a same-cycle Mealy match pulse. It counts matches and halts with an interrupt when the count reaches the threshold. It replaces hard-coded per-pattern detector FSMs.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNTW, 8, width of match counter and threshold
LENW, 4, width of cfg_len; must hold MAXLEN

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset=0 clears state at the next rising clk edge)
cfg_valid  input  1  config request
cfg_ready  output  1  config can be accepted
cfg_pattern  input  MAXLEN  pattern; bit [len-1] is received first, bit [0] last
cfg_len  input  LENW  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_threshold  input  CNTW  halt after this many matches; 0 = never halt
stop  input  1  abort RUN and return to IDLE
x_valid  input  1  serial bit qualifier
x  input  1  serial data bit
y  output  1  Mealy match pulse (combinational from x/x_valid)
match_count  output  CNTW  matches since last config or irq_clr
irq  output  1  threshold reached (level, sticky)
irq_clr  input  1  acknowledge irq, resume scanning
cfg_err  output  1  last config had an illegal length (sticky until next good config)
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset state: IDLE. Outputs: cfg_ready=1, y=0, match_count=0, irq=0, cfg_err=0. History register and fill counter are 0.
- States: IDLE=0, RUN=1, HALT=2. cfg_ready=1 in IDLE and HALT, 0 in RUN.
- Config handshake: a config is accepted when cfg_valid && cfg_ready.
  - Legal length (1..MAXLEN): latch all fields, clear count, history, fill, irq and cfg_err; go to RUN on the next cycle.
  - Illegal length (0 or >MAXLEN): set cfg_err and go to IDLE. No other field changes.
- RUN: on each x_valid cycle, cand = {hist, x}.
  - y=1 combinationally when (fill+1 >= len) and cand[len-1:0] == pattern[len-1:0].
  - Clock edge: hist <= cand; fill <= min(fill+1, MAXLEN).
  - If y=1 and overlap=0, fill <= 0 instead.
  - Cycles with x_valid=0 are ignored: y=0, no state change.
- Counter: match_count increments on each y, saturating at all-ones.
- Threshold: when threshold != 0 and count+1 == threshold on a match, set irq=1 and go to HALT. y is still 1 in that cycle.
- HALT: y=0 and x is ignored.
  - irq_clr=1 clears irq, match_count and fill, and returns to RUN. History content is don't-care because fill=0.
- stop in RUN: go to IDLE next cycle, and y is forced to 0 in the stop cycle. Count and irq are held. stop in IDLE or HALT is ignored.
- Priority in HALT when events coincide: cfg accept > irq_clr.
- Reset mid-RUN: returns to the reset state regardless of other inputs. The config must be reloaded.
- len=1 is legal: every x_valid bit equal to pattern[0] matches.
- Latency: y has zero cycles from x. match_count, irq and state update one cycle after the triggering edge inputs.

Decomposition:
- Package seq_detect_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_HALT) and the default MAXLEN, CNTW and LENW values.
- One sub-module, seq_match_core: history shift register, fill counter and length-masked compare (produces y given enable, len, pattern, overlap). The parent holds the config registers, FSM, counter and irq.

Test Plan:
- Reset, then cfg pattern=0b1010, len=4, overlap=1, thr=0. Stream 1,0,0,1,0,1,0,1,0,0 with x_valid=1 -> y=1 on bits 7 and 9 (1-indexed), match_count=2, irq=0.
- Same stream with overlap=0 -> y only on bit 7, match_count=1.
- pattern=0b1010, len=4, overlap=1, thr=2 with the same stream -> y and irq on bit 9, state_o=HALT. Further x ignored (y=0, count held at 2). Pulse irq_clr -> irq=0, count=0, state_o=RUN.
- Config cfg_len=0 -> cfg_err=1, state_o=IDLE. Then a legal config with len=3 -> cfg_err=0, RUN.
- In RUN with pattern 0b11, len=2, drive x=1 with x_valid toggling 1,0,1,0,1 -> matches only on the valid cycles 3 and 5. Then assert stop concurrently with a matching bit -> y=0, IDLE next cycle.
- Drive reset=0 mid-RUN with cfg_valid=1 -> next cycle IDLE, match_count=0, irq=0, cfg_ready=1, and the config is ignored.
